// File: rtl/fifo_wr_arb.sv
// Round-robin burst arbiter feeding one FIFO write port; one cycle of arbitration latency.
// FULL stalls beats while holding the grant; a requester dropping REQ ends its burst early.
module fifo_wr_arb #(
  parameter int DATA_WIDTH = 8,
  parameter int N_REQ      = 4,
  parameter int BURST_LEN  = 4,
  parameter int ID_W       = $clog2(N_REQ)
) (
  input  logic                        W_CLK,
  input  logic                        W_RST,
  input  logic [N_REQ-1:0]            REQ,
  input  logic [N_REQ*DATA_WIDTH-1:0] REQ_DATA,
  output logic [N_REQ-1:0]            ACK,
  input  logic                        FULL,
  output logic                        W_INC,
  output logic [DATA_WIDTH-1:0]       WR_DATA,
  output logic [ID_W-1:0]             GNT_ID,
  output logic                        BUSY
);

  localparam int              CNT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [ID_W:0]   N_REQ_X   = (ID_W+1)'(N_REQ);
  localparam logic [ID_W-1:0] LAST_ID   = ID_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [ID_W-1:0]  sel_id;
  logic [ID_W:0]    scan;
  logic             req_gnt;
  logic             beat;

  // Scan offsets from high to low so the nearest requester above rr_ptr is the last writer.
  always_comb begin : rr_scan
    sel_id = rr_ptr_q;
    scan   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      scan = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (scan >= N_REQ_X) scan = scan - N_REQ_X;
      if (REQ[scan[ID_W-1:0]]) sel_id = scan[ID_W-1:0];
    end
  end

  assign req_gnt = REQ[gnt_id_q];
  assign beat    = (state_q == GRANT) && req_gnt && !FULL;
  assign GNT_ID  = gnt_id_q;

  always_comb begin : outputs
    ACK           = '0;
    ACK[gnt_id_q] = beat;
    W_INC         = beat;
    BUSY          = (state_q == GRANT);
    WR_DATA       = '0;
    if (state_q == GRANT) WR_DATA = REQ_DATA[int'(gnt_id_q)*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin : next_state
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_id_d   = gnt_id_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (|REQ) begin
          gnt_id_d   = sel_id;
          beat_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (beat) beat_cnt_d = beat_cnt_q + 1'b1;
        // A withdrawal only counts once FULL is clear; a stalled grant is never released.
        if ((beat && beat_cnt_q == LAST_BEAT) || (!req_gnt && !FULL)) begin
          state_d  = IDLE;
          rr_ptr_d = (gnt_id_q == LAST_ID) ? '0 : gnt_id_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      gnt_id_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_id_q   <= gnt_id_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Three arbiter configurations driven by word-queue requesters; expected writes come from
// a round-robin drain of those queues, checked by per-instance monitors at the falling edge.
`timescale 1ns/1ps
module tb_fifo_wr_arb;

  localparam int DW = 8;
  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0]    id;
    logic [DW-1:0] dat;
  } beat_t;

  task automatic chk(input int g, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL inst%0d %s: got %0h expected %0h at %0t", g, nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : inst
    localparam int G  = g;
    localparam int N  = (g == 2) ? 3 : 4;
    localparam int B  = (g == 0) ? 4 : ((g == 1) ? 2 : 1);
    localparam int IW = $clog2(N);

    logic            rst_n;
    logic            full;
    logic            w_inc;
    logic            busy;
    logic [N-1:0]    req;
    logic [N-1:0]    ack;
    logic [N*DW-1:0] req_data;
    logic [DW-1:0]   wr_data;
    logic [IW-1:0]   gnt_id;

    logic [DW-1:0] rq [N][$];
    beat_t         exp_q [$];
    logic [1:0]    tim_q [$];
    int            mptr;
    bit            fin;

    fifo_wr_arb #(
      .DATA_WIDTH(DW),
      .N_REQ     (N),
      .BURST_LEN (B)
    ) dut (
      .W_CLK   (clk),
      .W_RST   (rst_n),
      .REQ     (req),
      .REQ_DATA(req_data),
      .ACK     (ack),
      .FULL    (full),
      .W_INC   (w_inc),
      .WR_DATA (wr_data),
      .GNT_ID  (gnt_id),
      .BUSY    (busy)
    );

    always @(negedge clk) begin : monitor
      beat_t      e;
      logic [1:0] t;
      if (w_inc) begin
        if (exp_q.size() == 0) begin
          chk(G, "unexpected_beat", 32'(w_inc), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk(G, "beat_gnt_id", 32'(gnt_id), 32'(e.id));
          chk(G, "beat_ack", 32'(ack), 32'd1 << e.id);
          chk(G, "beat_data", 32'(wr_data), 32'(e.dat));
        end
      end else begin
        chk(G, "ack_quiet", 32'(ack), 32'd0);
      end
      if (full) chk(G, "stall_no_winc", 32'(w_inc), 32'd0);
      if (tim_q.size() != 0) begin
        t = tim_q.pop_front();
        chk(G, "timed_winc", 32'(w_inc), 32'(t[0]));
        chk(G, "timed_busy", 32'(busy), 32'(t[1]));
        if (!t[1]) chk(G, "idle_data_zero", 32'(wr_data), 32'd0);
      end
    end

    function automatic bit rq_nonempty();
      bit any;
      any = 1'b0;
      for (int i = 0; i < N; i++) if (rq[i].size() != 0) any = 1'b1;
      return any;
    endfunction

    task automatic drive();
      for (int i = 0; i < N; i++) begin
        req[i] = (rq[i].size() != 0);
        req_data[i*DW +: DW] = req[i] ? rq[i][0] : DW'($urandom);
      end
    endtask

    task automatic check_reset_outputs(input string tag);
      chk(G, {tag, "_winc"}, 32'(w_inc), 32'd0);
      chk(G, {tag, "_ack"}, 32'(ack), 32'd0);
      chk(G, {tag, "_busy"}, 32'(busy), 32'd0);
      chk(G, {tag, "_wr_data"}, 32'(wr_data), 32'd0);
      chk(G, {tag, "_gnt_id"}, 32'(gnt_id), 32'd0);
    endtask

    // lens[i] words are queued on requester i; the reference drains them in round-robin
    // bursts of at most B words. timed phases (no FULL) also predict the cycle pattern:
    // one arbitration cycle, the beats, and one withdrawal cycle for a short burst.
    task automatic run_phase(input int lens[4], input int full_pct, input bit timed, input int abort_at);
      int           cur [4];
      int           idx;
      int           k;
      int           cyc;
      beat_t        be;
      logic [N-1:0] ack_s;
      for (int i = 0; i < N; i++) begin
        cur[i] = 0;
        for (int j = 0; j < lens[i]; j++) rq[i].push_back(DW'($urandom));
      end
      for (int r = 0; r < 64; r++) begin
        idx = -1;
        for (int o = 0; o < N; o++)
          if (idx < 0 && cur[(mptr + o) % N] < lens[(mptr + o) % N]) idx = (mptr + o) % N;
        if (idx < 0) break;
        k = lens[idx] - cur[idx];
        if (k > B) k = B;
        if (timed) tim_q.push_back(2'b00);
        for (int j = 0; j < k; j++) begin
          be.id  = 4'(idx);
          be.dat = rq[idx][cur[idx] + j];
          exp_q.push_back(be);
          if (timed) tim_q.push_back(2'b11);
        end
        if (timed && k < B) tim_q.push_back(2'b10);
        cur[idx] += k;
        mptr = (idx + 1) % N;
      end
      if (timed) begin
        tim_q.push_back(2'b00);
        tim_q.push_back(2'b00);
      end
      cyc = 0;
      while ((rq_nonempty() || exp_q.size() != 0 || tim_q.size() != 0) && cyc < 400) begin
        drive();
        full = rq_nonempty() && ($urandom_range(99) < full_pct);
        @(negedge clk);
        ack_s = ack;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
          if (ack_s[i] && rq[i].size() != 0) void'(rq[i].pop_front());
        cyc++;
        if (abort_at != 0 && cyc == abort_at) begin
          #1 rst_n = 1'b0;
          #1;
          check_reset_outputs("midburst_reset");
          for (int i = 0; i < N; i++) rq[i].delete();
          exp_q.delete();
          tim_q.delete();
          mptr = 0;
          full = 1'b0;
          drive();
          @(posedge clk);
          #1 rst_n = 1'b1;
          return;
        end
      end
      chk(G, "phase_drained", 32'(rq_nonempty() || exp_q.size() != 0 || tim_q.size() != 0), 32'd0);
      full = 1'b0;
      drive();
      repeat (2) @(posedge clk);
      #1;
    endtask

    initial begin : stim
      int l [4];
      fin      = 1'b0;
      rst_n    = 1'b1;
      full     = 1'b0;
      req      = '0;
      req_data = '0;
      mptr     = 0;
      #2 rst_n = 1'b0;
      #1;
      check_reset_outputs("reset");
      @(posedge clk);
      #1 rst_n = 1'b1;

      if (G == 0)      l = '{6, 0, 0, 0};
      else if (G == 1) l = '{4, 4, 4, 4};
      else             l = '{2, 0, 2, 0};
      run_phase(l, 0, 1'b1, 0);

      repeat (3) begin
        for (int i = 0; i < 4; i++) l[i] = int'($urandom_range(0, 6));
        run_phase(l, 0, 1'b1, 0);
      end
      repeat (4) begin
        for (int i = 0; i < 4; i++) l[i] = int'($urandom_range(0, 7));
        run_phase(l, 40, 1'b0, 0);
      end

      l = '{5, 5, 5, 5};
      run_phase(l, 0, 1'b0, 3);
      l = '{0, 0, 3, 3};
      run_phase(l, 0, 1'b1, 0);

      repeat (3) begin
        for (int i = 0; i < 4; i++) l[i] = int'($urandom_range(0, 7));
        run_phase(l, 60, 1'b0, 0);
      end
      fin = 1'b1;
    end
  end

  initial begin : finisher
    int n;
    n = 0;
    while (!(inst[0].fin && inst[1].fin && inst[2].fin) && n < 60000) begin
      @(posedge clk);
      n++;
    end
    chk(0, "all_instances_done", {29'd0, inst[2].fin, inst[1].fin, inst[0].fin}, 32'd7);
    #20;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
